// File: rtl/median_filter_sequencer.sv
// Sequencer for a 5-tap moving-median datapath: strobe decimation, pipeline flush,
// window-fill tracking and output qualification through a tag delay line.
module median_filter_sequencer #(
  parameter int WINDOW   = 5,
  parameter int PIPE_LAT = 7,
  parameter int DECIM_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Restart,
  input  logic               SampleStrobe,
  input  logic [DECIM_W-1:0] Decimation,
  output logic               DpReset,
  output logic               DpShift,
  output logic               Primed,
  output logic               OutValid,
  output logic [1:0]         State
);

  localparam int FLUSH_W = $clog2(PIPE_LAT + 1);
  localparam int FILL_W  = $clog2(WINDOW + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PIPE_LAT);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WINDOW - 1);
  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WINDOW);
  localparam logic [DECIM_W-1:0] DEC_ZERO   = {DECIM_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [FLUSH_W-1:0]  flush_cnt_r, flush_cnt_s;
  logic [FILL_W-1:0]   fill_cnt_r, fill_cnt_s;
  logic [DECIM_W-1:0]  dec_cnt_r, dec_cnt_s;
  logic [PIPE_LAT-1:0] tag_r, tag_s;
  logic                dp_reset_r, dp_reset_s;
  logic                primed_r, primed_s;
  logic                active_s, accept_s, fresh_s;

  // Accept qualification; a restart in the same cycle wins over the strobe.
  always_comb begin
    active_s = (state_r == ST_FILL) || (state_r == ST_RUN);
    accept_s = SampleStrobe && active_s && (dec_cnt_r == DEC_ZERO) && !Restart;
    if (state_r == ST_RUN) begin
      fresh_s = accept_s;
    end else if (state_r == ST_FILL) begin
      fresh_s = accept_s && (fill_cnt_r == FILL_LAST);
    end else begin
      fresh_s = 1'b0;
    end
  end

  // Next-state logic; a dropped Enable overrides everything else.
  always_comb begin
    state_s = state_r;
    if (!Enable) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!Restart && (flush_cnt_r == FLUSH_LAST)) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_FLUSH;
          end
        end
        ST_FILL: begin
          if (Restart) begin
            state_s = ST_FLUSH;
          end else if (accept_s && (fill_cnt_r == FILL_LAST)) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_FILL;
          end
        end
        ST_RUN: begin
          if (Restart) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_RUN;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Counter and delay-line next values; the flush counter restarts on every FLUSH entry.
  always_comb begin
    flush_cnt_s = {FLUSH_W{1'b0}};
    fill_cnt_s  = fill_cnt_r;
    dec_cnt_s   = dec_cnt_r;
    tag_s       = tag_r;

    if ((state_r == ST_FLUSH) && !Restart) begin
      flush_cnt_s = flush_cnt_r + {{(FLUSH_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_s = {FLUSH_W{1'b0}};
    end

    if (!active_s) begin
      fill_cnt_s = {FILL_W{1'b0}};
    end else if (accept_s && (fill_cnt_r != FILL_FULL)) begin
      fill_cnt_s = fill_cnt_r + {{(FILL_W-1){1'b0}}, 1'b1};
    end else begin
      fill_cnt_s = fill_cnt_r;
    end

    // Decimation is only sampled when the counter reloads.
    if (!active_s) begin
      dec_cnt_s = DEC_ZERO;
    end else if (SampleStrobe) begin
      if (dec_cnt_r == DEC_ZERO) begin
        dec_cnt_s = Decimation;
      end else begin
        dec_cnt_s = dec_cnt_r - {{(DECIM_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dec_cnt_s = dec_cnt_r;
    end

    if ((state_s == ST_IDLE) || (state_s == ST_FLUSH)) begin
      tag_s = {PIPE_LAT{1'b0}};
    end else begin
      tag_s = PIPE_LAT'({tag_r, fresh_s});
    end

    dp_reset_s = (state_s == ST_IDLE) || (state_s == ST_FLUSH);
    primed_s   = (state_s == ST_RUN);
  end

  // State, counters, tag delay line and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= {FLUSH_W{1'b0}};
      fill_cnt_r  <= {FILL_W{1'b0}};
      dec_cnt_r   <= DEC_ZERO;
      tag_r       <= {PIPE_LAT{1'b0}};
      dp_reset_r  <= 1'b1;
      primed_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
      fill_cnt_r  <= fill_cnt_s;
      dec_cnt_r   <= dec_cnt_s;
      tag_r       <= tag_s;
      dp_reset_r  <= dp_reset_s;
      primed_r    <= primed_s;
    end
  end

  // The last delay-line flop is the OutValid register: PIPE_LAT cycles after the tagged shift.
  assign DpShift  = accept_s;
  assign DpReset  = dp_reset_r;
  assign Primed   = primed_r;
  assign OutValid = tag_r[PIPE_LAT-1];
  assign State    = state_r;

endmodule

// File: tb/tb_median_filter_sequencer.sv
// Directed bench for median_filter_sequencer: per-cycle output history is recorded
// and compared against hand-derived cycle positions.
module tb_median_filter_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        Restart = 1'b0;
  logic        SampleStrobe = 1'b0;
  logic [15:0] Decimation = 16'd0;
  logic        DpReset, DpShift, Primed, OutValid;
  logic [1:0]  State;

  int n_chk  = 0;
  int n_pass = 0;
  int cix    = 0;

  logic [63:0] sh_h, dr_h, ov_h, pr_h;
  logic [1:0]  st_h [64];

  median_filter_sequencer #(.WINDOW(5), .PIPE_LAT(7), .DECIM_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Restart(Restart),
    .SampleStrobe(SampleStrobe), .Decimation(Decimation),
    .DpReset(DpReset), .DpShift(DpShift), .Primed(Primed),
    .OutValid(OutValid), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Record n cycles with the current inputs held; sampling is mid-cycle.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      #2;
      if (cix < 64) begin
        sh_h[cix] = DpShift;
        dr_h[cix] = DpReset;
        ov_h[cix] = OutValid;
        pr_h[cix] = Primed;
        st_h[cix] = State;
      end
      cix++;
      @(posedge Clk); #1;
    end
  endtask

  function automatic int cnt1(input logic [63:0] v, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(v[i]);
    return s;
  endfunction

  initial begin
    // Reset values
    SampleStrobe = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    #2;
    chk("rst_state", State, 0);
    chk("rst_dpreset", DpReset, 1);
    chk("rst_dpshift", DpShift, 0);
    chk("rst_primed", Primed, 0);
    chk("rst_outvalid", OutValid, 0);
    @(posedge Clk); #1;

    // 1: enable, Decimation=0, strobe every cycle
    Reset = 1'b0; Enable = 1'b1; Decimation = 16'd0;
    cix = 0; run(30);
    chk("t1_idle_c0", st_h[0], 0);
    chk("t1_flush_first", st_h[1], 1);
    chk("t1_flush_last", st_h[8], 1);
    chk("t1_dpreset_len", cnt1(dr_h, 1, 8), 8);
    chk("t1_fill_entry", st_h[9], 2);
    chk("t1_dpreset_off", dr_h[9], 0);
    chk("t1_no_shift_flush", sh_h[8], 0);
    chk("t1_fill_shifts", cnt1(sh_h, 9, 13), 5);
    chk("t1_fill_at_5th", st_h[13], 2);
    chk("t1_run_entry", st_h[14], 3);
    chk("t1_primed_before", pr_h[13], 0);
    chk("t1_primed_after", pr_h[14], 1);
    chk("t1_no_early_valid", cnt1(ov_h, 0, 19), 0);
    chk("t1_first_valid", ov_h[20], 1);
    chk("t1_valid_cont", cnt1(ov_h, 20, 29), 10);

    // 2: Decimation=3 in RUN
    Decimation = 16'd3;
    cix = 0; run(30);
    for (int c = 0; c < 20; c++) chk("t2_shift", sh_h[c], (c % 4 == 0) ? 1 : 0);
    chk("t2_inflight", cnt1(ov_h, 0, 7), 8);
    for (int c = 8; c < 28; c++) chk("t2_valid", ov_h[c], (c % 4 == 3) ? 1 : 0);

    // 5: Decimation 3->1 while the counter holds 2
    Decimation = 16'd1;
    cix = 0; run(12);
    for (int c = 0; c < 12; c++) chk("t5_shift", sh_h[c], (c >= 2 && c % 2 == 0) ? 1 : 0);

    // 3: Restart in RUN with a full pipe of tags
    Decimation = 16'd0;
    cix = 0; run(10);
    chk("t3_prefill", cnt1(sh_h, 0, 9), 10);
    cix = 0;
    Restart = 1'b1; run(1);
    Restart = 1'b0; run(30);
    chk("t3_restart_noshift", sh_h[0], 0);
    chk("t3_valid_at_restart", ov_h[0], 1);
    chk("t3_valid_killed", cnt1(ov_h, 1, 19), 0);
    chk("t3_flush_entry", st_h[1], 1);
    chk("t3_flush_last", st_h[8], 1);
    chk("t3_dpreset_len", cnt1(dr_h, 1, 8), 8);
    chk("t3_fill_entry", st_h[9], 2);
    chk("t3_primed_low", cnt1(pr_h, 1, 13), 0);
    chk("t3_primed_back", pr_h[14], 1);
    chk("t3_valid_back", ov_h[20], 1);

    // 4: Enable dropped after 3 accepts in FILL, re-raised 10 cycles later
    cix = 0;
    Restart = 1'b1; run(1);
    Restart = 1'b0; run(11);
    Enable = 1'b0; SampleStrobe = 1'b0; run(10);
    Enable = 1'b1; SampleStrobe = 1'b1; run(25);
    chk("t4_three_accepts", cnt1(sh_h, 9, 11), 3);
    chk("t4_fill_before", st_h[12], 2);
    chk("t4_idle", st_h[13], 0);
    chk("t4_idle_dpreset", cnt1(dr_h, 13, 21), 9);
    chk("t4_no_valid", cnt1(ov_h, 1, 41), 0);
    chk("t4_idle_reenable", st_h[22], 0);
    chk("t4_reflush", st_h[23], 1);
    chk("t4_reflush_len", cnt1(dr_h, 23, 30), 8);
    chk("t4_refill", st_h[31], 2);
    chk("t4_refill_dpreset", dr_h[31], 0);
    chk("t4_fill_at_5th", st_h[35], 2);
    chk("t4_primed_before", pr_h[35], 0);
    chk("t4_run", st_h[36], 3);
    chk("t4_primed", pr_h[36], 1);
    chk("t4_first_valid", ov_h[42], 1);

    // 6: Reset mid-RUN, then all-ones decimation
    Decimation = 16'hFFFF;
    cix = 0;
    Reset = 1'b1; run(1);
    Reset = 1'b0; run(30);
    chk("t6_state", st_h[1], 0);
    chk("t6_dpreset", dr_h[1], 1);
    chk("t6_dpshift", sh_h[1], 0);
    chk("t6_primed", pr_h[1], 0);
    chk("t6_outvalid", ov_h[1], 0);
    chk("t6_fill", st_h[10], 2);
    chk("t6_first_accept", sh_h[10], 1);
    chk("t6_max_decim", cnt1(sh_h, 1, 30), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
